tx_wr_arbiter: RTL and testbench
================================

Name: tx_wr_arbiter

Overview:
- Round-robin arbiter and byte serializer for the system-clock write port of the TX async FIFO.
- Shares the FIFO between NUM_REQ requesters, e.g. register-read responses, 16-bit ALU results and status bytes.
- Each requester presents a one- or two-byte frame. The block grants one requester at a time and pushes its bytes LSB-first into the FIFO, honouring full.
- It then acknowledges the requester and moves the round-robin pointer on.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_WIDTH, 8, FIFO data byte width; each requester word is 2*DATA_WIDTH.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous reset, active-high.
- i_req  input  NUM_REQ  per-requester request level; held until the matching o_ack.
- i_len  input  NUM_REQ  per-requester frame length: 0 = 1 byte, 1 = 2 bytes.
- i_data  input  NUM_REQ*2*DATA_WIDTH  flattened words; requester k occupies bits [k*2*DATA_WIDTH +: 2*DATA_WIDTH].
- i_ff_full  input  1  FIFO full flag in the i_clk domain.
- o_wr_data  output  DATA_WIDTH  FIFO write data.
- o_winc  output  1  FIFO write strobe; one byte per cycle high.
- o_grant  output  NUM_REQ  one-hot registered grant; zero when idle.
- o_ack  output  NUM_REQ  one-cycle completion pulse to the granted requester.
- o_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (synchronous, i_rst=1 at a rising edge):
  - state=IDLE, rr pointer=0, latched word/len/grant cleared.
  - o_grant=0, o_ack=0, o_busy=0, o_wr_data=0.
  - o_winc is gated combinationally by ~i_rst, so no write occurs in any cycle where i_rst=1.
- States: IDLE, SEND_LO, SEND_HI, DONE.
- IDLE:
  - If any i_req bit is set, select the first set bit searching upward from the pointer, wrapping at NUM_REQ-1 -> 0.
  - Latch that requester's i_data and i_len, set o_grant one-hot, go to SEND_LO.
  - Otherwise stay in IDLE.
- SEND_LO:
  - o_wr_data = latched word[DATA_WIDTH-1:0].
  - o_winc = ~i_ff_full (combinational).
  - If full, hold the state with o_winc=0.
  - When the write occurs: go to SEND_HI if len=1, else to DONE.
- SEND_HI:
  - Same as SEND_LO with the upper byte.
  - When the write occurs, go to DONE.
- DONE:
  - o_ack[g]=1 for exactly this cycle.
  - Pointer <= (g+1) mod NUM_REQ; o_grant cleared on exit; return to IDLE.
- Full handling:
  - i_ff_full is sampled in the same cycle as o_winc. The FIFO updates full one edge after a write, so back-to-back byte writes are legal.
  - A stall of any length is allowed; bytes are never dropped or duplicated.
- Latency with no stall:
  - i_req sampled in IDLE at cycle 0.
  - Grant and LO write at cycle 1, HI write at cycle 2 (2-byte frames only).
  - ACK at cycle 3 (2-byte) or cycle 2 (1-byte).
  - IDLE one cycle after ACK.
- Requester rules:
  - Requesters drop i_req on the edge at which they see o_ack, so the next IDLE cycle does not re-grant them.
  - i_data and i_len changes after the grant are ignored because they are latched.
  - A request dropped before it is granted is simply never served.
  - New requests during a busy frame wait for IDLE.
- Fairness:
  - With all requesters continuously asserting, grants follow 0,1,..,NUM_REQ-1,0,...
  - Each requester waits at most NUM_REQ-1 frames.
- Reset mid-frame:
  - The partial frame is abandoned with no ack and no further writes.
  - Any byte already written stays in the FIFO.
- Invariants:
  - o_winc is high only in SEND_LO or SEND_HI, and only with i_ff_full=0.
  - o_grant is at most one-hot.
  - o_ack is a subset of o_grant.

Test Plan:
- Req1 only, i_len[1]=0, data1=0x0033, full=0 -> single o_winc with o_wr_data=0x33 at cycle 1; o_ack=3'b010 at cycle 2; o_busy low at cycle 3.
- Req1 only, i_len[1]=1, data1=0xA55A -> writes 0x5A then 0xA5 on consecutive cycles; ack at cycle 3; exactly 2 strobes.
- Same 2-byte frame with i_ff_full=1 for cycles 2-5 -> 0x5A at cycle 1, no strobe during cycles 2-5, 0xA5 at cycle 6, ack at cycle 7.
- All three requesting with 1-byte frames data0=0x10, data1=0x11, data2=0x12, re-asserted after each ack -> byte stream 10,11,12,10,11,12; acks in order 0,1,2.
- Reset at pointer=2: req0 and req2 asserted -> grant 2 first, then 0 (wrap).
- i_rst asserted in the cycle between LO and HI writes of 0xBEEF -> only 0xEF written, no ack, state IDLE, pointer 0, o_grant 0 afterwards.

Source files
------------

// File: rtl/tx_wr_arbiter.sv
// Round-robin arbiter and LSB-first byte serializer feeding the system-clock
// write port of the TX async FIFO. One requester is granted at a time, its
// one- or two-byte frame is pushed into the FIFO while honouring full, then the
// requester is acknowledged and the round-robin pointer advances.
module tx_wr_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_REQ-1:0]              i_req,
    input  logic [NUM_REQ-1:0]              i_len,
    input  logic [NUM_REQ*2*DATA_WIDTH-1:0] i_data,
    input  logic                            i_ff_full,
    output logic [DATA_WIDTH-1:0]           o_wr_data,
    output logic                            o_winc,
    output logic [NUM_REQ-1:0]              o_grant,
    output logic [NUM_REQ-1:0]              o_ack,
    output logic                            o_busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int WW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [PW-1:0]        ptr_q;
    logic [PW-1:0]        gidx_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [WW-1:0]        word_q;
    logic                 len_q;

    logic                 found;
    logic [PW-1:0]        sel_idx;

    // First pending requester searching upward from the pointer, wrapping at NUM_REQ-1
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            int unsigned cand;
            cand = 32'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && i_req[cand[PW-1:0]]) begin
                found   = 1'b1;
                sel_idx = cand[PW-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; byte states advance only when the write actually happens
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                if (!i_ff_full) begin
                    state_d = len_q ? SEND_HI : DONE;
                end
            end
            SEND_HI: begin
                if (!i_ff_full) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the granted frame on grant; advance the pointer and drop grant on completion
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            word_q  <= '0;
            len_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && found) begin
                gidx_q  <= sel_idx;
                grant_q <= NUM_REQ'(1) << sel_idx;
                word_q  <= i_data[int'(sel_idx)*WW +: WW];
                len_q   <= i_len[sel_idx];
            end else if (state_q == DONE) begin
                grant_q <= '0;
                if (gidx_q == PW'(NUM_REQ - 1)) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= gidx_q + PW'(1);
                end
            end
        end
    end

    // Outputs decoded from state; write strobe also gated by full and reset
    always_comb begin
        o_wr_data = '0;
        o_winc    = 1'b0;
        o_ack     = '0;
        o_busy    = (state_q != IDLE);
        case (state_q)
            SEND_LO: begin
                o_wr_data = word_q[DATA_WIDTH-1:0];
                o_winc    = ~i_ff_full & ~i_rst;
            end
            SEND_HI: begin
                o_wr_data = word_q[WW-1:DATA_WIDTH];
                o_winc    = ~i_ff_full & ~i_rst;
            end
            DONE: begin
                o_ack = grant_q;
            end
            default: begin
            end
        endcase
    end

    assign o_grant = grant_q;

endmodule

// File: tb/tb_tx_wr_arbiter.sv
// Scoreboard bench for tx_wr_arbiter: stimulus pushes expected writes and acks
// (with the cycle they must appear in); a monitor pops and compares them.
module tb_tx_wr_arbiter;

    localparam int NR = 3;
    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 i_rst;
    logic [NR-1:0]        i_req;
    logic [NR-1:0]        i_len;
    logic [NR*2*DW-1:0]   i_data;
    logic                 i_ff_full;
    logic [DW-1:0]        o_wr_data;
    logic                 o_winc;
    logic [NR-1:0]        o_grant;
    logic [NR-1:0]        o_ack;
    logic                 o_busy;

    typedef struct {
        logic [DW-1:0] data;
        logic [NR-1:0] grant;
        int            cyc;
    } wr_t;

    typedef struct {
        logic [NR-1:0] ack;
        int            cyc;
    } ack_t;

    wr_t  wr_q[$];
    ack_t ack_q[$];
    wr_t  we;
    ack_t ae;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int t0;

    logic          rearm = 1'b0;
    logic [NR-1:0] ack_s = '0;
    logic [NR-1:0] dropped_last = '0;

    tx_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_req     (i_req),
        .i_len     (i_len),
        .i_data    (i_data),
        .i_ff_full (i_ff_full),
        .o_wr_data (o_wr_data),
        .o_winc    (o_winc),
        .o_grant   (o_grant),
        .o_ack     (o_ack),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every strobe and every ack against the scoreboard
    always @(negedge clk) begin
        if (o_winc) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got data 0x%0h expected no write (cycle %0d)", o_wr_data, cyc);
            end else begin
                we = wr_q.pop_front();
                check("wr_data", 32'(o_wr_data), 32'(we.data));
                check("wr_cycle", 32'(cyc), 32'(we.cyc));
                check("wr_grant", 32'(o_grant), 32'(we.grant));
            end
        end
        if (o_ack != '0) begin
            check("ack_subset_grant", 32'(o_ack & ~o_grant), 32'd0);
            if (ack_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got 0x%0h expected no ack (cycle %0d)", o_ack, cyc);
            end else begin
                ae = ack_q.pop_front();
                check("ack_value", 32'(o_ack), 32'(ae.ack));
                check("ack_cycle", 32'(cyc), 32'(ae.cyc));
            end
        end
    end

    // Requester model: drop request the edge after its ack; optionally re-raise one cycle later
    always @(negedge clk) ack_s = o_ack;

    always @(posedge clk) begin
        #1;
        i_req = (i_req & ~ack_s) | (rearm ? dropped_last : '0);
        dropped_last = ack_s;
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) next_cycle();
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (o_busy && k < budget) begin
            next_cycle();
            k++;
        end
        if (o_busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0 within %0d cycles", budget);
        end
    endtask

    task automatic set_req(input int k, input logic len, input logic [2*DW-1:0] w);
        i_data[k*2*DW +: 2*DW] = w;
        i_len[k] = len;
        i_req[k] = 1'b1;
    endtask

    task automatic exp_wr(input logic [DW-1:0] d, input logic [NR-1:0] g, input int c);
        wr_t e;
        e.data = d;
        e.grant = g;
        e.cyc = c;
        wr_q.push_back(e);
    endtask

    task automatic exp_ack(input logic [NR-1:0] a, input int c);
        ack_t e;
        e.ack = a;
        e.cyc = c;
        ack_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        i_req = '0;
        i_len = '0;
        i_data = '0;
        i_ff_full = 1'b0;
        next_cycle();
        next_cycle();
        i_rst = 1'b0;

        // Reset state
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_ack", 32'(o_ack), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_wr_data", 32'(o_wr_data), 32'd0);
        check("rst_winc", 32'(o_winc), 32'd0);

        // 1-byte frame from requester 1
        t0 = cyc;
        set_req(1, 1'b0, 16'h0033);
        exp_wr(8'h33, 3'b010, t0 + 1);
        exp_ack(3'b010, t0 + 2);
        wait_until(t0 + 3);
        check("t1_busy_low", 32'(o_busy), 32'd0);

        // 2-byte frame, no stall
        t0 = cyc;
        set_req(1, 1'b1, 16'hA55A);
        exp_wr(8'h5A, 3'b010, t0 + 1);
        exp_wr(8'hA5, 3'b010, t0 + 2);
        exp_ack(3'b010, t0 + 3);
        wait_until(t0 + 4);
        check("t2_busy_low", 32'(o_busy), 32'd0);

        // 2-byte frame with full held for cycles 2..5
        t0 = cyc;
        set_req(1, 1'b1, 16'hA55A);
        exp_wr(8'h5A, 3'b010, t0 + 1);
        exp_wr(8'hA5, 3'b010, t0 + 6);
        exp_ack(3'b010, t0 + 7);
        wait_until(t0 + 2);
        i_ff_full = 1'b1;
        wait_until(t0 + 4);
        check("t3_stall_grant", 32'(o_grant), 32'b010);
        wait_until(t0 + 6);
        i_ff_full = 1'b0;
        wait_idle(20);

        // Reset pointer back to 0
        i_rst = 1'b1;
        next_cycle();
        i_rst = 1'b0;

        // Fairness: all three continuously requesting 1-byte frames
        t0 = cyc;
        set_req(0, 1'b0, 16'h0010);
        set_req(1, 1'b0, 16'h0011);
        set_req(2, 1'b0, 16'h0012);
        rearm = 1'b1;
        for (int f = 0; f < 6; f++) begin
            exp_wr(8'h10 + 8'(f % 3), 3'(1 << (f % 3)), t0 + 1 + 3 * f);
            exp_ack(3'(1 << (f % 3)), t0 + 2 + 3 * f);
        end
        wait_until(t0 + 16);
        rearm = 1'b0;
        i_req = 3'b100;
        wait_until(t0 + 19);
        check("t4_req_cleared", 32'(i_req), 32'd0);

        // Pointer to 2 via requester 1, then req0+req2 -> 2 first, wrap to 0
        t0 = cyc;
        set_req(1, 1'b0, 16'h0021);
        exp_wr(8'h21, 3'b010, t0 + 1);
        exp_ack(3'b010, t0 + 2);
        wait_until(t0 + 3);
        t0 = cyc;
        set_req(0, 1'b0, 16'h0030);
        set_req(2, 1'b0, 16'h0032);
        exp_wr(8'h32, 3'b100, t0 + 1);
        exp_ack(3'b100, t0 + 2);
        exp_wr(8'h30, 3'b001, t0 + 4);
        exp_ack(3'b001, t0 + 5);
        wait_until(t0 + 6);

        // Reset between LO and HI writes: only LO byte, no ack, pointer back to 0
        t0 = cyc;
        set_req(1, 1'b1, 16'hBEEF);
        exp_wr(8'hEF, 3'b010, t0 + 1);
        wait_until(t0 + 2);
        i_rst = 1'b1;
        i_req = '0;
        next_cycle();
        i_rst = 1'b0;
        check("t6_busy", 32'(o_busy), 32'd0);
        check("t6_grant", 32'(o_grant), 32'd0);
        check("t6_ack", 32'(o_ack), 32'd0);
        t0 = cyc;
        set_req(0, 1'b0, 16'h0040);
        set_req(1, 1'b0, 16'h0041);
        exp_wr(8'h40, 3'b001, t0 + 1);
        exp_ack(3'b001, t0 + 2);
        exp_wr(8'h41, 3'b010, t0 + 4);
        exp_ack(3'b010, t0 + 5);
        wait_until(t0 + 6);

        wait_idle(20);
        next_cycle();
        next_cycle();
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        check("ack_queue_drained", 32'(ack_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
